// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE sequencing controller: FSM states, layer mode,
// PE mux select encodings and the registered strobe bundle.
package pe_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StClr,
        StLoad,
        StMulStart,
        StMulWait,
        StAddStart,
        StAddWait,
        StAccWr,
        StBiasLoad,
        StPool,
        StOfWr,
        StOut
    } state_e;

    typedef enum logic {
        ModeConv = 1'b0,
        ModePool = 1'b1
    } mode_e;

    localparam logic ActnSelConv = 1'b1;
    localparam logic ActnSelPool = 1'b0;
    localparam logic WtSelWeight = 1'b1;
    localparam logic WtSelBias   = 1'b0;
    localparam logic AddSelMult  = 1'b0;
    localparam logic AddSelBias  = 1'b1;
    localparam logic OutSelConv  = 1'b0;
    localparam logic OutSelPool  = 1'b1;

    typedef struct packed {
        logic cmd_ready;
        logic in_ready;
        logic acc_clr;
        logic mult_load;
        logic add_start;
        logic acc_wr_en;
        logic of_rf_wr_en;
        logic out_valid;
        logic if_rf_wr_en;
        logic wt_rf_wr_en;
        logic actn_in_sel;
        logic wt_in_sel;
        logic add_in_sel;
        logic pe_out_sel;
    } strb_t;

    localparam strb_t StrbReset = '{cmd_ready: 1'b1, default: 1'b0};

endpackage

// File: rtl/pe_ctrl_wait.sv
// Request/response wait unit: holds en from start until done, with an
// optional watchdog (PE_CTRL_TIMEOUT_EN) that gives up after TIMEOUT_CYC cycles.
module pe_ctrl_wait #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic done,
    output logic en,
    output logic fin,
    output logic tmo
);

    logic en_q;

    assign en  = en_q;
    // done is only meaningful while waiting, including the first wait cycle
    assign fin = en_q & done;

`ifdef PE_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (start || !en_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tmo = en_q & ~done & (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q <= 1'b0;
        end else if (start) begin
            en_q <= 1'b1;
        end else if (fin || tmo) begin
            en_q <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_ctrl.sv
// Single-PE sequencing controller: command + beat stream in, registered PE
// strobes out. Optional response watchdog under PE_CTRL_TIMEOUT_EN.
module pe_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_mode,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_actn,
    input  logic [DATA_WIDTH-1:0] in_filt,
    output logic [DATA_WIDTH-1:0] actn_in,
    output logic [DATA_WIDTH-1:0] filt_in,
    output logic                  actn_in_sel,
    output logic                  wt_in_sel,
    output logic                  add_in_sel,
    output logic                  pe_out_sel,
    output logic                  if_rf_wr_en,
    output logic                  wt_rf_wr_en,
    output logic                  of_rf_wr_en,
    output logic                  mult_en,
    output logic                  mult_load,
    output logic                  add_en,
    output logic                  acc_wr_en,
    output logic                  acc_clr,
    input  logic [1:0]            pe_resp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, tap_q, tap_d, tap_inc;
    logic [DATA_WIDTH-1:0] actn_q, actn_d, filt_q, filt_d;
    strb_t                 strb_q, strb_d;
    logic                  cmd_acc, beat_acc, last_tap;
    logic                  mul_busy, mul_fin, mul_tmo;
    logic                  add_busy, add_fin, add_tmo;

    assign cmd_acc  = cmd_valid & strb_q.cmd_ready;
    assign beat_acc = in_valid & strb_q.in_ready;
    assign tap_inc  = tap_q + 1'b1;
    assign last_tap = (tap_inc == len_q);

    pe_ctrl_wait #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_mul_wait (
        .clk   (clk),
        .rst   (rst),
        .start (state_q == StMulStart),
        .done  (pe_resp[0]),
        .en    (mul_busy),
        .fin   (mul_fin),
        .tmo   (mul_tmo)
    );

    pe_ctrl_wait #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_add_wait (
        .clk   (clk),
        .rst   (rst),
        .start (state_q == StAddStart),
        .done  (pe_resp[1]),
        .en    (add_busy),
        .fin   (add_fin),
        .tmo   (add_tmo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (cmd_acc) state_d = StClr;
            StClr: begin
                if (len_q != '0)            state_d = StLoad;
                else if (mode_q == ModePool) state_d = StOfWr;
                else                         state_d = StBiasLoad;
            end
            StLoad:     if (beat_acc) state_d = (mode_q == ModeConv) ? StMulStart : StPool;
            StMulStart: state_d = StMulWait;
            StMulWait: begin
                if (mul_fin)      state_d = StAddStart;
                else if (mul_tmo) state_d = StIdle;
            end
            StAddStart: state_d = StAddWait;
            StAddWait: begin
                if (add_fin)      state_d = StAccWr;
                else if (add_tmo) state_d = StIdle;
            end
            // add_in_sel marks the bias add, the last accumulation of a conv layer
            StAccWr: begin
                if (strb_q.add_in_sel == AddSelBias) state_d = StOfWr;
                else if (last_tap)                   state_d = StBiasLoad;
                else                                 state_d = StLoad;
            end
            StBiasLoad: if (beat_acc) state_d = StAddStart;
            StPool:     state_d = last_tap ? StOfWr : StLoad;
            StOfWr:     state_d = StOut;
            StOut:      if (out_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        len_d  = len_q;
        tap_d  = tap_q;
        actn_d = actn_q;
        filt_d = filt_q;
        strb_d = '0;
        strb_d.actn_in_sel = strb_q.actn_in_sel;
        strb_d.wt_in_sel   = strb_q.wt_in_sel;
        strb_d.add_in_sel  = strb_q.add_in_sel;
        strb_d.pe_out_sel  = strb_q.pe_out_sel;

        if (cmd_acc) begin
            mode_d = mode_e'(cmd_mode);
            len_d  = cmd_len;
            tap_d  = '0;
            strb_d.actn_in_sel = (mode_e'(cmd_mode) == ModeConv) ? ActnSelConv : ActnSelPool;
            strb_d.wt_in_sel   = (mode_e'(cmd_mode) == ModeConv) ? WtSelWeight : WtSelBias;
            strb_d.add_in_sel  = AddSelMult;
            strb_d.pe_out_sel  = (mode_e'(cmd_mode) == ModeConv) ? OutSelConv : OutSelPool;
        end
        if (state_q == StAccWr || state_q == StPool) tap_d = tap_inc;
        if (beat_acc) begin
            filt_d = in_filt;
            if (state_q == StLoad) actn_d = in_actn;
        end
        if (beat_acc && state_q == StBiasLoad) begin
            strb_d.wt_in_sel  = WtSelBias;
            strb_d.add_in_sel = AddSelBias;
        end

        strb_d.cmd_ready   = (state_d == StIdle);
        strb_d.in_ready    = (state_d == StLoad) || (state_d == StBiasLoad);
        strb_d.acc_clr     = (state_d == StClr);
        strb_d.mult_load   = (state_d == StMulStart);
        strb_d.add_start   = (state_d == StAddStart);
        strb_d.acc_wr_en   = (state_d == StAccWr);
        strb_d.of_rf_wr_en = (state_d == StOfWr);
        strb_d.out_valid   = (state_d == StOut);
        strb_d.if_rf_wr_en = beat_acc && (state_q == StLoad);
        strb_d.wt_rf_wr_en = beat_acc && ((state_q == StLoad && mode_q == ModeConv) ||
                                          state_q == StBiasLoad);

        if (state_d == StIdle) begin
            strb_d.actn_in_sel = 1'b0;
            strb_d.wt_in_sel   = 1'b0;
            strb_d.add_in_sel  = 1'b0;
            strb_d.pe_out_sel  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            mode_q  <= ModeConv;
            len_q   <= '0;
            tap_q   <= '0;
            actn_q  <= '0;
            filt_q  <= '0;
            strb_q  <= StrbReset;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            tap_q   <= tap_d;
            actn_q  <= actn_d;
            filt_q  <= filt_d;
            strb_q  <= strb_d;
        end
    end

`ifdef PE_CTRL_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (mul_tmo || add_tmo) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready   = strb_q.cmd_ready;
    assign in_ready    = strb_q.in_ready;
    assign actn_in     = actn_q;
    assign filt_in     = filt_q;
    assign actn_in_sel = strb_q.actn_in_sel;
    assign wt_in_sel   = strb_q.wt_in_sel;
    assign add_in_sel  = strb_q.add_in_sel;
    assign pe_out_sel  = strb_q.pe_out_sel;
    assign if_rf_wr_en = strb_q.if_rf_wr_en;
    assign wt_rf_wr_en = strb_q.wt_rf_wr_en;
    assign of_rf_wr_en = strb_q.of_rf_wr_en;
    assign mult_en     = mul_busy;
    assign mult_load   = strb_q.mult_load;
    // add_en covers the start cycle plus the response wait
    assign add_en      = strb_q.add_start | add_busy;
    assign acc_wr_en   = strb_q.acc_wr_en;
    assign acc_clr     = strb_q.acc_clr;
    assign out_valid   = strb_q.out_valid;

endmodule
